// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: M-extension op codes, controller states and divide-cache record shared by the MDU controller
package mdu_ctrl_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  typedef enum logic [2:0] {
    MDUC_IDLE,
    MDUC_ISSUE,
    MDUC_WAIT,
    MDUC_WB,
    MDUC_DRAIN
  } mduc_state_e;
  typedef struct packed {
    logic        valid;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quo;
    logic [31:0] rem;
  } div_cache_t;
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: launch/completion bus between the core-side controller and the iterative MDU
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  modport master (output start, funct3, a, b, input busy, done, product, quotient, remainder);
  modport slave (input start, funct3, a, b, output busy, done, product, quotient, remainder);
endinterface

// File: rtl/mdu_special_case.sv
// mdu_special_case: resolves divide-by-zero and signed-overflow divides without the MDU
module mdu_special_case
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        hit,
  output logic [31:0] result
);
  logic is_rem, dz, ovf;
  assign is_rem = funct3 == F3_REM || funct3 == F3_REMU;
  assign dz     = is_div(funct3) && b == '0;
  assign ovf    = (funct3 == F3_DIV || funct3 == F3_REM) && a == INT32_MIN && b == '1;
  assign hit    = dz || ovf;
  assign result = dz ? (is_rem ? a : '1) : (is_rem ? '0 : INT32_MIN);
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: stalls execute for M-extension ops, fast-paths special/cached divides, else launches the MDU and writes back
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  mdu_ctrl_if.master  mdu
);
  mduc_state_e state, state_n;
  div_cache_t  cache;
  logic        sc_hit, c_hit, accept, fin;
  logic [31:0] sc_res, fast_res, mdu_res;

  mdu_special_case u_special (
    .funct3(req_funct3),
    .a     (req_a),
    .b     (req_b),
    .hit   (sc_hit),
    .result(sc_res)
  );

  assign accept   = state == MDUC_IDLE && req_valid && !flush;
  assign c_hit    = cache.valid && is_div(req_funct3) && cache.sgn == !req_funct3[0] &&
                    cache.a == req_a && cache.b == req_b;
  assign fast_res = sc_hit ? sc_res : req_funct3[1] ? cache.rem : cache.quo;
  assign fin      = state == MDUC_WAIT && mdu.done && !flush;
  assign mdu_res  = mdu.funct3 == F3_MUL ? mdu.product[31:0] :
                    mdu.funct3 inside {F3_MULH, F3_MULHSU, F3_MULHU} ? mdu.product[63:32] :
                    mdu.funct3 inside {F3_DIV, F3_DIVU} ? mdu.quotient : mdu.remainder;
  assign stall    = accept || state == MDUC_ISSUE || state == MDUC_WAIT ||
                    (state == MDUC_DRAIN && req_valid);

  always_comb begin
    state_n = state;
    unique case (state)
      MDUC_IDLE:  state_n = accept ? (sc_hit || c_hit ? MDUC_WB : MDUC_ISSUE) : MDUC_IDLE;
      MDUC_ISSUE: state_n = MDUC_WAIT;
      MDUC_WAIT:  state_n = flush ? (mdu.done ? MDUC_IDLE : MDUC_DRAIN) : mdu.done ? MDUC_WB : MDUC_WAIT;
      MDUC_WB:    state_n = MDUC_IDLE;
      MDUC_DRAIN: state_n = mdu.done ? MDUC_IDLE : MDUC_DRAIN;
      default:    state_n = MDUC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MDUC_IDLE;
      cache      <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      mdu.start  <= 1'b0;
      mdu.funct3 <= '0;
      mdu.a      <= '0;
      mdu.b      <= '0;
    end else begin
      state     <= state_n;
      wb_valid  <= state_n == MDUC_WB;
      mdu.start <= state_n == MDUC_ISSUE;
      if (accept) begin
        mdu.funct3 <= req_funct3;
        mdu.a      <= req_a;
        mdu.b      <= req_b;
        wb_rd      <= req_rd;
      end
      if (accept && (sc_hit || c_hit))
        wb_data <= fast_res;
      if (fin)
        wb_data <= mdu_res;
      // flushed or drained completions never reach here, so they cannot poison the cache
      if (fin && is_div(mdu.funct3))
        cache <= '{valid: 1'b1, sgn: !mdu.funct3[0], a: mdu.a, b: mdu.b,
                   quo: mdu.quotient, rem: mdu.remainder};
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) mdu.start |-> !(mdu.busy || mdu.done));
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table, hand-sequence and randomized checks of mdu_ctrl against an architectural M-extension model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 0, rst_n = 0, req_valid = 0, flush = 0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mdu_ctrl_if mif ();

  mdu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_funct3(req_funct3),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .flush     (flush),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mdu       (mif)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mdl_lat = 0;
  bit c_v = 0, c_s = 0;
  logic [31:0] c_a = '0, c_b = '0;

  // Architectural RISC-V M result, including the divide corner cases
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p;
    bit ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    bit hit = f3[2] && c_v && c_s == !f3[0] && c_a == a && c_b == b;
    return !special && !hit;
  endfunction

  // MDU behavioural model: registers start, iterates for a few cycles, pulses done
  initial begin
    int cnt;
    bit pend;
    logic [2:0] f;
    logic [31:0] x, y;
    cnt = 0; pend = 0; f = '0; x = '0; y = '0;
    mif.busy = 0; mif.done = 0; mif.product = '0; mif.quotient = '0; mif.remainder = '0;
    forever begin
      @(posedge clk); #1;
      mif.done = 0;
      if (!rst_n) begin
        mif.busy = 0; cnt = 0; pend = 0;
      end else if (pend) begin
        pend = 0; mif.busy = 1;
        cnt = mdl_lat != 0 ? mdl_lat : int'($urandom_range(1, 5));
        f = mif.funct3; x = mif.a; y = mif.b;
      end else if (mif.busy) begin
        cnt--;
        if (cnt == 0) begin
          mif.busy = 0; mif.done = 1;
          mif.product   = {ref_m(f == 3'd0 ? 3'd3 : f, x, y), ref_m(3'd0, x, y)};
          mif.quotient  = ref_m({2'b10, f[0]}, x, y);
          mif.remainder = ref_m({2'b11, f[0]}, x, y);
        end
      end
      if (rst_n && mif.start) pend = 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one op in an IDLE cycle and follow it to writeback
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit launch, input string tag);
    int starts, start_cyc, cyc;
    bit got, stall_ok, prev_done;
    starts = 0; start_cyc = 0; got = 0; stall_ok = 1; prev_done = 0;
    @(negedge clk);
    req_valid = 1; req_funct3 = f3; req_a = a; req_b = b; req_rd = rd;
    #1;
    check({tag, "/stall_req"}, stall, 1);
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (mif.start) begin
        starts++;
        if (start_cyc == 0) start_cyc = cyc;
      end
      if (wb_valid) begin got = 1; break; end
      stall_ok &= stall;
      prev_done = mif.done;
    end
    req_valid = 0;
    check({tag, "/wb_seen"}, got, 1);
    check({tag, "/launches"}, starts, launch ? 1 : 0);
    if (got) begin
      check({tag, "/wb_data"}, wb_data, exp);
      check({tag, "/wb_rd"}, wb_rd, rd);
      check({tag, "/stall_wb"}, stall, 0);
      if (launch) begin
        check({tag, "/start_cycle"}, start_cyc, 1);
        check({tag, "/wb_after_done"}, prev_done, 1);
        check({tag, "/stall_held"}, stall_ok, 1);
      end else
        check({tag, "/fast_latency"}, cyc, 1);
      if (launch && f3[2]) begin
        c_v = 1; c_s = !f3[0]; c_a = a; c_b = b;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          launch;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{F3_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1};
    vt[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFE,  1};
    vt[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'd2,          5'd7,  32'hFFFF_FFFF,  1};
    vt[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF,  1};
    vt[4]  = '{F3_DIV,    32'h1234,       32'd0,          5'd9,  32'hFFFF_FFFF,  0};
    vt[5]  = '{F3_REM,    32'hFFFF_FFFB,  32'd0,          5'd10, 32'hFFFF_FFFB,  0};
    vt[6]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  0};
    vt[7]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h0,          0};
    vt[8]  = '{F3_DIVU,   32'd100,        32'd7,          5'd13, 32'd14,         1};
    vt[9]  = '{F3_REMU,   32'd100,        32'd7,          5'd14, 32'd2,          0};
    vt[10] = '{F3_REM,    32'd100,        32'd7,          5'd15, 32'd2,          1};
    vt[11] = '{F3_DIV,    32'd100,        32'd7,          5'd16, 32'd14,         0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/wb_valid", wb_valid, 0);
    check("rst/mdu_start", mif.start, 0);
    check("rst/wb_rd", wb_rd, 0);
    check("rst/wb_data", wb_data, 0);
    check("rst/mdu_funct3", mif.funct3, 0);
    check("rst/mdu_a", mif.a, 0);
    check("rst/mdu_b", mif.b, 0);
    check("rst/stall_idle", stall, 0);
    req_valid = 1; #1;
    check("rst/stall_req", stall, 1);
    req_valid = 0; #1;
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i])
      run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].launch, $sformatf("vec%0d", i));

    // Flush in WAIT, then a new MUL arriving during DRAIN
    begin
      bit saw_done, got, stall_ok;
      int early;
      saw_done = 0; got = 0; stall_ok = 1; early = 0;
      mdl_lat = 6;
      @(negedge clk);
      req_valid = 1; req_funct3 = F3_DIVU; req_a = 32'd1000; req_b = 32'd3; req_rd = 5'd4;
      @(negedge clk);
      check("flush/start", mif.start, 1);
      @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0; req_funct3 = F3_MUL; req_a = 32'd3; req_b = 32'd3; req_rd = 5'd9;
      #1;
      check("drain/stall", stall, 1);
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (mif.start && !saw_done) early++;
        if (mif.done) saw_done = 1;
        if (wb_valid) begin got = 1; break; end
        stall_ok &= stall;
      end
      req_valid = 0;
      check("drain/wb_seen", got, 1);
      check("drain/start_in_drain", early, 0);
      check("drain/old_done_seen", saw_done, 1);
      check("drain/stall_held", stall_ok, 1);
      check("drain/wb_data", wb_data, 9);
      check("drain/wb_rd", wb_rd, 9);
      mdl_lat = 0;
    end
    run_op(F3_DIVU, 32'd1000, 32'd3, 5'd4, 32'd333, 1, "post_flush_divu");

    // Reset in the middle of WAIT
    begin
      int wbs;
      wbs = 0;
      mdl_lat = 6;
      @(negedge clk);
      req_valid = 1; req_funct3 = F3_DIV; req_a = 32'd1000; req_b = 32'd7; req_rd = 5'd3;
      repeat (3) @(negedge clk);
      rst_n = 0; #1;
      check("midrst/wb_valid", wb_valid, 0);
      check("midrst/mdu_start", mif.start, 0);
      check("midrst/wb_rd", wb_rd, 0);
      check("midrst/wb_data", wb_data, 0);
      check("midrst/mdu_funct3", mif.funct3, 0);
      check("midrst/mdu_a", mif.a, 0);
      check("midrst/mdu_b", mif.b, 0);
      check("midrst/stall_req", stall, 1);
      req_valid = 0; #1;
      check("midrst/stall_idle", stall, 0);
      c_v = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (10) begin
        @(negedge clk);
        if (wb_valid) wbs++;
      end
      check("midrst/no_wb", wbs, 0);
      mdl_lat = 0;
    end
    run_op(F3_DIV, 32'd100, 32'd7, 5'd2, 32'd14, 1, "post_rst_div");

    // Randomized ops with operands biased toward corner cases and cache reuse
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      logic [4:0] rd;
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom);
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'h0;
        2: a = 32'h8000_0000;
        default: a = 32'd100;
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'h0;
        2: b = 32'hFFFF_FFFF;
        default: b = 32'd7;
      endcase
      run_op(f3, a, b, rd, ref_m(f3, a, b), ref_launch(f3, a, b), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Core-side controller for the iterative multiply/divide unit. It receives decoded M-extension instructions from the execute stage and stalls the pipeline. It either resolves the instruction directly (division special cases and a DIV/REM result cache) or launches the MDU and waits for its `done` pulse. It then selects the architectural 32-bit result and presents it to register-file writeback.

## Interface
Parameters: none.

- `clk`  in  1  core clock
- `rst_n`  in  1  reset; asynchronous assertion, active-low
- `req_valid`  in  1  M-extension instruction present in execute; held stable while `stall`=1
- `req_funct3`  in  3  op select, standard RISC-V M encoding (MUL=000 … REMU=111)
- `req_a`, `req_b`  in  32  rs1/rs2 values
- `req_rd`  in  5  destination register
- `flush`  in  1  kill the instruction currently held in execute
- `stall`  out  1  combinational pipeline hold
- `wb_valid`  out  1  registered, one-cycle writeback strobe
- `wb_rd`  out  5  destination for `wb_data`
- `wb_data`  out  32  result
- `mdu_start`  out  1  registered, one-cycle launch pulse
- `mdu_funct3`  out  3  latched op
- `mdu_a`, `mdu_b`  out  32  latched operands
- `mdu_busy`  in  1  MDU iterating
- `mdu_done`  in  1  one-cycle completion pulse
- `mdu_product`  in  64  MDU product
- `mdu_quotient`, `mdu_remainder`  in  32  MDU divide results

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- **IDLE** with `req_valid & !flush`:
  - Latch funct3, a, b and rd.
  - Special case or cache hit: register the result and go to WB.
  - Otherwise go to ISSUE.
- **Special cases** (MDU not launched):
  - b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- **Cache** (one entry):
  - Contents: {valid, signed, a, b, quotient, remainder}.
  - Written on every MDU divide completion that reaches WB.
  - Hit: a divide-class op with the same a, b and signedness (DIV/REM signed; DIVU/REMU unsigned) returns the cached quotient or remainder.
  - Multiplies never hit.
  - Cleared only by reset.
- **ISSUE**: `mdu_start`=1 for exactly this cycle; go to WAIT.
- **WAIT**:
  - On `mdu_done`, select the result and go to WB.
  - MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32]; DIV/DIVU → quotient; REM/REMU → remainder.
  - On `flush` (with or without `mdu_done`): go to DRAIN, or straight to IDLE if `mdu_done`=1 that cycle. No writeback, no cache update.
- **WB**: `wb_valid`=1 for one cycle; return to IDLE. `flush` in WB is ignored, because the instruction is already retiring.
- **DRAIN**: the MDU cannot be aborted. Wait for `mdu_done`, discard the result, then return to IDLE. Requests are not accepted in DRAIN.
- `stall` = (IDLE & req_valid & !flush) | ISSUE | WAIT | (DRAIN & req_valid).
- Requests presented while in WB are ignored; the pipeline advances at the end of WB.

## Timing
- **Reset**:
  - State IDLE; cache invalid.
  - `wb_valid`, `mdu_start` = 0.
  - `wb_rd`, `wb_data`, `mdu_funct3`, `mdu_a`, `mdu_b` = 0.
  - `stall` follows the IDLE equation.
- **Reset mid-operation**: the controller returns to IDLE with no writeback. The MDU is reset by the same `rst_n`.
- **Fast path**: request in cycle T; `stall`=1 in T; `wb_valid`=1 and `stall`=0 in T+1.
- **MDU path**:
  - Request in cycle T; `mdu_start` in T+1; WAIT from T+2.
  - `mdu_done` in cycle D; `wb_valid` in D+1.
  - `stall`=1 for T…D.
- **Back-to-back**: a new request is accepted at the earliest in the cycle after WB.
- **`mdu_start` guard**: never asserted while `mdu_busy`=1 or in the cycle `mdu_done`=1. If violated, this is a design error; assert in simulation.

## Structure
- **Shared defines**:
  - FUNCT3 op constants come from `riscv_defines.vh`.
  - Add `MDUC_*` state encodings to `riscv_defines.vh`.
  - Add 0x80000000 as `INT32_MIN` to `riscv_defines.vh`.
- **Sub-module**: one natural combinational sub-module, `mdu_special_case`. It takes (funct3, a, b) and returns {hit, result}.
- Cache compare and the result mux stay inline.
- Target size: roughly 200 lines.

## Test plan
- **MUL fast-launch**: MUL a=7, b=6, rd=5 → one `mdu_start` pulse; `wb_valid` with `wb_rd`=5 and `wb_data`=42; `stall` falls in the `wb_valid` cycle.
- **MULHU high word**: MULHU a=b=0xFFFFFFFF → `wb_data`=0xFFFFFFFE. MULH a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- **Divide by zero**: DIV a=0x1234, b=0 → no `mdu_start`; `wb_data`=0xFFFFFFFF at T+1. REM a=0xFFFFFFFB, b=0 → 0xFFFFFFFB at T+1.
- **Signed overflow**: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0. No launch in either case.
- **Cache reuse**:
  - DIVU 100/7 → 14 with a launch.
  - Then REMU 100/7 → 2 with no `mdu_start` and a 1-cycle stall.
  - Then REM 100/7 → launches, giving 2.
- **Flush and reset**:
  - Flush in WAIT of DIVU 1000/3 → no `wb_valid`.
  - A new MUL 3×3 presented during DRAIN stays stalled until the old `mdu_done`, then launches and writes back 9.
  - `rst_n` low mid-WAIT → all outputs return to reset values.
